// File: rtl/led_fader.sv
// led_fader
//   Drives CH board LEDs with PWM brightness. Each channel's brightness level
//   ramps one step at a time toward its target: full on when the matching
//   data_in bit is 1, off when it is 0. The LEDs therefore fade instead of
//   switching hard. The module sits between the pattern generator and the LED
//   pins and runs in the same clock domain as both.
//
//   Optional feature: define LED_FADER_GAMMA_EN to map the level to the duty
//   cycle through a square-law (gamma) curve. When the macro is undefined,
//   the duty cycle equals the level.
//
// Parameters
//   CH        number of LED channels (width of data_in / leds)
//   PWM_W     brightness and PWM resolution in bits; MAX = 2**PWM_W-1
//   STEP_DIV  clk_in cycles per brightness step (>= 1)
//
// Ports
//   clk_in   in   1    system clock, rising edge
//   rst      in   1    asynchronous active-high reset
//   data_in  in   CH   target pattern
//   leds     out  CH   registered PWM drive
//   busy     out  1    high while any channel level differs from its target
module led_fader #(
  parameter int CH       = 4,
  parameter int PWM_W    = 4,
  parameter int STEP_DIV = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic [CH-1:0] data_in,
  output logic [CH-1:0] leds,
  output logic          busy
);

  localparam logic [PWM_W-1:0] MAX  = '1;
  localparam logic [PWM_W-1:0] ZERO = '0;
  // A divider of 1 still needs a 1-bit counter, which stays at 0.
  localparam int              SC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_DIV - 1);

  logic [CH-1:0]    data_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic [SC_W-1:0]  step_cnt;
  logic             step_tick;
  logic [PWM_W-1:0] level  [CH];
  logic [PWM_W-1:0] target [CH];
  logic [PWM_W-1:0] duty   [CH];

  assign step_tick = (step_cnt == SC_LAST);

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      target[i] = data_q[i] ? MAX : ZERO;
`ifdef LED_FADER_GAMMA_EN
      // Full-width square, then keep the upper half: (level*level) >> PWM_W.
      duty[i] = PWM_W'(({ZERO, level[i]} * {ZERO, level[i]}) >> PWM_W);
`else
      duty[i] = level[i];
`endif
    end
  end

  // busy depends only on registers (level, data_q), so it cannot glitch
  // on data_in.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      busy = busy | (level[i] != target[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      leds     <= '0;
      for (int i = 0; i < CH; i++) begin
        level[i] <= ZERO;
      end
    end else begin
      data_q   <= data_in;
      pwm_cnt  <= pwm_cnt + PWM_W'(1);
      step_cnt <= step_tick ? '0 : step_cnt + SC_W'(1);
      for (int i = 0; i < CH; i++) begin
        // Level MAX is forced on so that full brightness has no one-cycle
        // dark gap when pwm_cnt equals MAX.
        leds[i] <= (level[i] == MAX) | (duty[i] > pwm_cnt);
        // Step toward the target. Because equal levels hold, the count
        // stops at 0 and at MAX and never wraps.
        if (step_tick) begin
          if (level[i] < target[i]) begin
            level[i] <= level[i] + PWM_W'(1);
          end else if (level[i] > target[i]) begin
            level[i] <= level[i] - PWM_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader
//   Self-checking bench for led_fader. Three instances share the clock and
//   the reset:
//     dut       STEP_DIV=8, checked every cycle against a reference model
//               through an expected-value queue.
//     dut_slow  STEP_DIV=64, so that each level is held long enough to count
//               the PWM duty over a whole 16-cycle window.
//     dut_fast  STEP_DIV=1, used for the fast-toggle saturation case.
module tb_led_fader;

  localparam int CH    = 4;
  localparam int MAXV  = 15;
  localparam int SDIV  = 8;

  logic          clk_in  = 1'b0;
  logic          rst     = 1'b1;
  logic [CH-1:0] data_in = '0;
  logic [CH-1:0] data_s  = '0;
  logic [CH-1:0] data_f  = '0;
  logic [CH-1:0] leds, leds_s, leds_f;
  logic          busy, busy_s, busy_f;

  int errors = 0;
  int checks = 0;

  // Expected {busy, leds} after each rising edge of dut.
  logic [CH:0] exp_q[$];

  // Reference model state for dut.
  logic [CH-1:0] m_data_q;
  logic [3:0]    m_pwm;
  int            m_step;
  int            m_level [CH];

  always #5 clk_in = ~clk_in;

  led_fader #(.CH(CH), .PWM_W(4), .STEP_DIV(SDIV)) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in), .leds(leds), .busy(busy));
  led_fader #(.CH(CH), .PWM_W(4), .STEP_DIV(64)) dut_slow (
    .clk_in(clk_in), .rst(rst), .data_in(data_s), .leds(leds_s), .busy(busy_s));
  led_fader #(.CH(CH), .PWM_W(4), .STEP_DIV(1)) dut_fast (
    .clk_in(clk_in), .rst(rst), .data_in(data_f), .leds(leds_f), .busy(busy_f));

  function automatic int duty_of(int l);
`ifdef LED_FADER_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  // Number of high cycles in any 16-cycle window at a constant level.
  function automatic int exp_high(int l);
    return (l == MAXV) ? 16 : duty_of(l);
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    data_in = '0; data_s = '0; data_f = '0;
    wait_edges(2);
  endtask

  // Reference model and scoreboard. The model advances on each rising edge
  // and pushes the output it expects after that edge; the falling edge pops
  // one entry and compares it with the DUT.
  task automatic scoreboard();
    logic [CH:0]   exp_v, act_v;
    logic [CH-1:0] nl;
    logic          nb;
    bit            tick;
    int            tgt;
    forever begin
      @(posedge clk_in or negedge clk_in or posedge rst);
      if (rst) begin
        m_data_q = '0; m_pwm = '0; m_step = 0;
        for (int i = 0; i < CH; i++) m_level[i] = 0;
        exp_q.delete();
      end else if (clk_in) begin
        for (int i = 0; i < CH; i++)
          nl[i] = (m_level[i] == MAXV) || (duty_of(m_level[i]) > int'(m_pwm));
        tick   = (m_step == SDIV - 1);
        m_step = tick ? 0 : m_step + 1;
        m_pwm  = m_pwm + 4'd1;
        if (tick) begin
          for (int i = 0; i < CH; i++) begin
            tgt = m_data_q[i] ? MAXV : 0;
            if (m_level[i] < tgt) m_level[i]++;
            else if (m_level[i] > tgt) m_level[i]--;
          end
        end
        m_data_q = data_in;
        nb = 1'b0;
        for (int i = 0; i < CH; i++)
          nb = nb | (m_level[i] != (m_data_q[i] ? MAXV : 0));
        exp_q.push_back({nb, nl});
      end else if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {busy, leds};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL scoreboard t=%0t {busy,leds} got %b expected %b", $time, act_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      wait_edges(1);
      checks++;
      if ({busy, leds} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d {busy,leds} got %b expected 00000", c, {busy, leds});
      end
    end
    rst = 1'b0;
    wait_edges(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_busy got %b expected 1", busy);
    end
  endtask

  // Counts rising edges after reset release until busy drops (budget 200).
  task automatic measure_fall(input string name);
    int fall_at;
    fall_at = 201;
    for (int c = 1; c <= 200; c++) begin
      wait_edges(1);
      if (busy === 1'b0) begin
        fall_at = c;
        break;
      end
    end
    checks++;
    if (fall_at != 120) begin
      errors++;
      $display("FAIL %s busy fell at edge %0d expected 120", name, fall_at);
    end
  endtask

  task automatic test_single_channel();
    int hi0, hi_other;
    apply_reset();
    data_in = 4'b0001;
    rst = 1'b0;
    measure_fall("single_ramp");
    hi0 = 0; hi_other = 0;
    for (int c = 0; c < 32; c++) begin
      wait_edges(1);
      hi0 += int'(leds[0]);
      hi_other += int'(leds[3:1] != 3'b0);
    end
    checks++;
    if (hi0 != 32) begin
      errors++;
      $display("FAIL full_on leds[0] high %0d of 32 expected 32", hi0);
    end
    checks++;
    if (hi_other != 0) begin
      errors++;
      $display("FAIL others_off leds[3:1] active %0d cycles expected 0", hi_other);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    data_in = 4'hF;
    rst = 1'b0;
    wait_edges(85);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_fade_busy got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, leds} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset {busy,leds} got %b expected 00000", {busy, leds});
    end
    wait_edges(1);
    rst = 1'b0;
    measure_fall("restart_ramp");
  endtask

  task automatic test_fade_reverse();
    int cnt, lvl, off;
    logic other;
    apply_reset();
    data_s = 4'b0001;
    rst = 1'b0;
    cnt = 0; other = 1'b0;
    for (int e = 1; e <= 640; e++) begin
      wait_edges(1);
      other = other | (leds_s[3:1] != 3'b0);
      if (e == 320) begin
        checks++;
        if (busy_s !== 1'b1) begin
          errors++;
          $display("FAIL reverse_busy_at5 got %b expected 1", busy_s);
        end
        data_s = 4'b0000;
      end
      if (e > 320) begin
        off = (e - 321) % 64;
        lvl = 5 - (e - 321) / 64;
        if (off >= 16 && off < 32) cnt += int'(leds_s[0]);
        if (off == 31) begin
          checks++;
          if (cnt != exp_high(lvl)) begin
            errors++;
            $display("FAIL down_duty level %0d high %0d of 16 expected %0d", lvl, cnt, exp_high(lvl));
          end
          cnt = 0;
        end
      end
      if (e == 639 || e == 640) begin
        checks++;
        if (busy_s !== (e == 639)) begin
          errors++;
          $display("FAIL down_end_busy edge %0d got %b expected %b", e, busy_s, e == 639);
        end
      end
    end
    checks++;
    if (other !== 1'b0) begin
      errors++;
      $display("FAIL down_others_off got %b expected 0", other);
    end
  endtask

  task automatic test_duty_levels();
    int cnt, lvl, off;
    apply_reset();
    data_s = 4'b0001;
    rst = 1'b0;
    cnt = 0;
    for (int e = 1; e <= 1024; e++) begin
      wait_edges(1);
      lvl = (e - 1) / 64;
      off = (e - 1) % 64;
      if (off >= 16 && off < 32) cnt += int'(leds_s[0]);
      if (off == 31) begin
        checks++;
        if (cnt != exp_high(lvl)) begin
          errors++;
          $display("FAIL up_duty level %0d high %0d of 16 expected %0d", lvl, cnt, exp_high(lvl));
        end
        cnt = 0;
      end
    end
  endtask

  task automatic test_fast_toggle();
    int max_lvl, idle;
    apply_reset();
    data_f = 4'hF;
    rst = 1'b0;
    max_lvl = 0; idle = 0;
    for (int e = 1; e <= 60; e++) begin
      wait_edges(1);
      for (int i = 0; i < CH; i++)
        if (int'(dut_fast.level[i]) > max_lvl) max_lvl = int'(dut_fast.level[i]);
      idle += int'(busy_f !== 1'b1);
      if (e % 3 == 0) data_f = ~data_f;
    end
    checks++;
    if (max_lvl != 3) begin
      errors++;
      $display("FAIL fast_toggle max level %0d expected 3", max_lvl);
    end
    checks++;
    if (idle != 0) begin
      errors++;
      $display("FAIL fast_toggle busy low %0d cycles expected 0", idle);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      data_in = 4'($urandom_range(0, 15));
      wait_edges($urandom_range(1, 40));
    end
    wait_edges(2);
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL queue_drain pending %0d expected at most 1", exp_q.size());
    end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_single_channel();
    test_async_reset();
    test_fade_reverse();
    test_duty_levels();
    test_fast_toggle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
